// File: rtl/uart_cmd_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_framer_if
// Purpose  : Bundles the byte-receiver, command-consumer, response-producer
//            and byte-transmitter signals used by uart_cmd_framer.
// Ports    : rx_rdy/rx_data/clr_rx_rdy      - byte receiver handshake
//            cmd/cmd_rdy/clr_cmd_rdy        - assembled command handshake
//            frame_err                      - partial-command discard pulse
//            resp_vld/resp/resp_busy/resp_sent - response request handshake
//            tx_trmt/tx_data/tx_done        - byte transmitter handshake
// Modports : master - the framer itself
//            slave  - the surrounding receiver/transmitter/consumer logic
// Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_framer_if #(
  parameter int CMD_BYTES  = 2,
  parameter int RESP_BYTES = 1
);

  logic                    rx_rdy;
  logic [7:0]              rx_data;
  logic                    clr_rx_rdy;
  logic [8*CMD_BYTES-1:0]  cmd;
  logic                    cmd_rdy;
  logic                    clr_cmd_rdy;
  logic                    frame_err;
  logic                    resp_vld;
  logic [8*RESP_BYTES-1:0] resp;
  logic                    resp_busy;
  logic                    resp_sent;
  logic                    tx_trmt;
  logic [7:0]              tx_data;
  logic                    tx_done;

  modport master (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp_vld, resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, frame_err, resp_busy, resp_sent,
           tx_trmt, tx_data
  );

  modport slave (
    output rx_rdy, rx_data, clr_cmd_rdy, resp_vld, resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, frame_err, resp_busy, resp_sent,
           tx_trmt, tx_data
  );

endinterface
`default_nettype wire

// File: rtl/uart_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_framer
// Purpose  : Assembles CMD_BYTES received UART bytes into one command word
//            (first byte in the MSBs) with an optional inter-byte timeout,
//            and serialises a RESP_BYTES response word MSB byte first to a
//            byte transmitter. RX and TX paths run independently.
// Ports    : clk  - single clock, posedge
//            rst  - synchronous active-high reset
//            bus  - uart_cmd_framer_if.master (receiver, command, response
//                   and transmitter handshakes)
// Params   : CMD_BYTES   (1..8) bytes per inbound command
//            RESP_BYTES  (1..8) bytes per outbound response
//            TIMEOUT_CYC idle cycles before a partial command is dropped
//                        (0 disables the timeout)
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_framer #(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_framer_if.master bus
);

  localparam int c_CMD_W  = 8 * CMD_BYTES;
  localparam int c_RESP_W = 8 * RESP_BYTES;
  localparam int c_CNT_W  = $clog2(CMD_BYTES) + 1;
  localparam int c_IDX_W  = $clog2(RESP_BYTES) + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CMD_BYTES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(RESP_BYTES - 1);
  localparam bit                 c_SINGLE   = (CMD_BYTES == 1);

  localparam logic [0:0] c_RX_IDLE  = 1'b0;
  localparam logic [0:0] c_RX_RCVNG = 1'b1;

  localparam logic [1:0] c_TX_IDLE = 2'd0;
  localparam logic [1:0] c_TX_SEND = 2'd1;
  localparam logic [1:0] c_TX_WAIT = 2'd2;

  // --------------------------------------------------------------------------
  // RX path
  // --------------------------------------------------------------------------
  logic [0:0]         r_rx_state;
  logic [c_CNT_W-1:0] r_rx_cnt;
  logic [c_CMD_W-1:0] r_cmd;
  logic               r_cmd_rdy;
  logic               r_frame_err;

  logic [c_CMD_W-1:0] w_frame;     // shift register contents plus current byte
  logic               w_complete;
  logic               w_new_frame;
  logic               w_timeout;

  // Every offered byte is taken immediately; no back-pressure exists.
  assign bus.clr_rx_rdy = bus.rx_rdy;

  assign w_complete  = bus.rx_rdy &&
                       (((r_rx_state == c_RX_IDLE) && c_SINGLE) ||
                        ((r_rx_state == c_RX_RCVNG) && (r_rx_cnt == c_CNT_LAST)));
  assign w_new_frame = bus.rx_rdy && (r_rx_state == c_RX_IDLE) && !c_SINGLE;

  // Only the CMD_BYTES-1 earlier bytes need storing; the last byte is taken
  // straight from rx_data when the command completes.
  generate
    if (CMD_BYTES > 1) begin : g_shift
      logic [c_CMD_W-9:0] r_shift;

      assign w_frame = {r_shift, bus.rx_data};

      always_ff @(posedge clk) begin
        if (rst) begin
          r_shift <= '0;
        end else if (bus.rx_rdy) begin
          r_shift <= w_frame[c_CMD_W-9:0];
        end
      end
    end else begin : g_no_shift
      assign w_frame = bus.rx_data;
    end
  endgenerate

  // Idle-cycle counter: restarts on every byte and outside RCVNG. The
  // terminal test excludes rx_rdy so a byte arriving on that cycle wins.
  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      localparam int c_TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

      logic [c_TO_W-1:0] r_idle_cnt;

      assign w_timeout = (r_rx_state == c_RX_RCVNG) && !bus.rx_rdy &&
                         (r_idle_cnt == c_TO_LAST);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_idle_cnt <= '0;
        end else if ((r_rx_state != c_RX_RCVNG) || bus.rx_rdy) begin
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state  <= c_RX_IDLE;
      r_rx_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_rx_state)
        c_RX_IDLE: begin
          if (bus.rx_rdy && !c_SINGLE) begin
            r_rx_cnt   <= c_CNT_W'(1);
            r_rx_state <= c_RX_RCVNG;
          end
        end
        c_RX_RCVNG: begin
          if (bus.rx_rdy) begin
            if (r_rx_cnt == c_CNT_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_state <= c_RX_IDLE;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            // Partial bytes are simply abandoned; cmd/cmd_rdy stay as-is.
            r_rx_cnt    <= '0;
            r_rx_state  <= c_RX_IDLE;
            r_frame_err <= 1'b1;
          end
        end
        default: begin
          r_rx_cnt   <= '0;
          r_rx_state <= c_RX_IDLE;
        end
      endcase
    end
  end

  // cmd_rdy: completion beats start-of-new-frame clear, which beats the
  // consumer acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
    end else if (w_complete) begin
      r_cmd     <= w_frame;
      r_cmd_rdy <= 1'b1;
    end else if (w_new_frame || bus.clr_cmd_rdy) begin
      r_cmd_rdy <= 1'b0;
    end
  end

  assign bus.cmd       = r_cmd;
  assign bus.cmd_rdy   = r_cmd_rdy;
  assign bus.frame_err = r_frame_err;

  // --------------------------------------------------------------------------
  // TX path
  // --------------------------------------------------------------------------
  logic [1:0]          r_tx_state;
  logic [c_RESP_W-1:0] r_resp;      // shifted left as bytes go out
  logic [c_IDX_W-1:0]  r_idx;
  logic                r_resp_busy;
  logic                r_resp_sent;
  logic                r_tx_trmt;
  logic [7:0]          r_tx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state  <= c_TX_IDLE;
      r_resp      <= '0;
      r_idx       <= '0;
      r_resp_busy <= 1'b0;
      r_resp_sent <= 1'b0;
      r_tx_trmt   <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_tx_trmt   <= 1'b0;
      r_resp_sent <= 1'b0;
      case (r_tx_state)
        c_TX_IDLE: begin
          // A request coinciding with the resp_sent pulse is dropped.
          if (bus.resp_vld && !r_resp_sent) begin
            r_resp      <= bus.resp;
            r_idx       <= '0;
            r_resp_busy <= 1'b1;
            r_tx_state  <= c_TX_SEND;
          end
        end
        c_TX_SEND: begin
          r_tx_trmt  <= 1'b1;
          r_tx_data  <= r_resp[c_RESP_W-1 -: 8];
          r_resp     <= r_resp << 8;
          r_tx_state <= c_TX_WAIT;
        end
        c_TX_WAIT: begin
          // r_tx_trmt is high exactly in the start-pulse cycle, so a
          // tx_done seen then belongs to a previous byte and is ignored.
          if (bus.tx_done && !r_tx_trmt) begin
            if (r_idx == c_IDX_LAST) begin
              r_resp_busy <= 1'b0;
              r_resp_sent <= 1'b1;
              r_tx_state  <= c_TX_IDLE;
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_tx_state <= c_TX_SEND;
            end
          end
        end
        default: begin
          r_resp_busy <= 1'b0;
          r_tx_state  <= c_TX_IDLE;
        end
      endcase
    end
  end

  assign bus.resp_busy = r_resp_busy;
  assign bus.resp_sent = r_resp_sent;
  assign bus.tx_trmt   = r_tx_trmt;
  assign bus.tx_data   = r_tx_data;

endmodule
`default_nettype wire
